// File: rtl/dz_pkg.sv
// Shared definitions for the dot-matrix scan path: scan FSM encoding,
// blank column level and the 8x8 glyph codes used by frame writers.
package dz_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SCAN = 2'd1,
    ST_PEND = 2'd2
  } scan_state_e;

  // Level driven on a column that must stay dark.
  localparam logic COL_OFF = 1'b0;

  // Glyphs available to writers (egg stages, chick, thermometer).
  typedef enum logic [2:0] {
    GL_EGG       = 3'd0,
    GL_EGG_CRACK = 3'd1,
    GL_EGG_HATCH = 3'd2,
    GL_CHICK     = 3'd3,
    GL_THERMO    = 3'd4
  } glyph_e;

  // Returns one 8-column row of a glyph; row 0 is the least significant byte.
  function automatic logic [7:0] glyph_row(glyph_e g, logic [2:0] r);
    logic [63:0] bits;
    case (g)
      GL_EGG:       bits = 64'h183C7E7E7E7E3C18;
      GL_EGG_CRACK: bits = 64'h183C5A667E7E3C18;
      GL_EGG_HATCH: bits = 64'h0018244281423C00;
      GL_CHICK:     bits = 64'h003C7E5A7E3C2466;
      GL_THERMO:    bits = 64'h3C3C242424241818;
      default:      bits = 64'h0;
    endcase
    return bits[{r, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dz_matrix_scan_if.sv
// Row-write and frame-commit port between a frame writer and the scanner.
//
// Handshake: a row write transfers on every rising edge where wr_valid and
// wr_ready are both 1; wr_row/wr_r/wr_g must be stable while wr_valid is 1.
// commit is a single-cycle request; commit_done is a single-cycle pulse
// issued by the scanner once the written frame becomes the displayed one.
interface dz_matrix_scan_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int RW = $clog2(ROWS);

  logic            wr_valid;
  logic            wr_ready;
  logic [RW-1:0]   wr_row;
  logic [COLS-1:0] wr_r;
  logic [COLS-1:0] wr_g;
  logic            commit;
  logic            commit_done;

  modport master (
    output wr_valid, wr_row, wr_r, wr_g, commit,
    input  wr_ready, commit_done
  );

  modport slave (
    input  wr_valid, wr_row, wr_r, wr_g, commit,
    output wr_ready, commit_done
  );
endinterface

// File: rtl/dz_frame_buf.sv
// Double-buffered frame store: two banks of ROWS x {red, green} words.
// Writes always land in the back bank; the scanner reads the front bank.
module dz_frame_buf #(
  parameter  int ROWS = 8,
  parameter  int COLS = 8,
  localparam int RW   = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_r,
  input  logic [COLS-1:0] wr_g,
  input  logic            swap,
  input  logic [RW-1:0]   rd_row,
  output logic [COLS-1:0] rd_r,
  output logic [COLS-1:0] rd_g
);

  // One extra bit so the bound check is meaningful when ROWS is a power of two.
  localparam logic [RW:0] ROW_LIMIT = (RW+1)'(ROWS);

  logic                front_q;
  logic [2*COLS-1:0]   bank0_q [ROWS];
  logic [2*COLS-1:0]   bank1_q [ROWS];
  logic                wr_hit;
  logic [2*COLS-1:0]   rd_word;

  // Rows outside the matrix complete the handshake but are not stored.
  assign wr_hit = wr_en && ({1'b0, wr_row} < ROW_LIMIT);

  // Front pointer: 0 shows bank0, 1 shows bank1.
  always_ff @(posedge clk) begin
    if (rst)       front_q <= 1'b0;
    else if (swap) front_q <= ~front_q;
  end

  // Bank storage; only the bank not being displayed accepts writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        bank0_q[i] <= '0;
        bank1_q[i] <= '0;
      end
    end else if (wr_hit) begin
      if (front_q) bank0_q[wr_row] <= {wr_r, wr_g};
      else         bank1_q[wr_row] <= {wr_r, wr_g};
    end
  end

  // Read mux for the row currently being scanned.
  always_comb begin
    rd_word = front_q ? bank1_q[rd_row] : bank0_q[rd_row];
  end

  assign rd_r = rd_word[2*COLS-1:COLS];
  assign rd_g = rd_word[COLS-1:0];

endmodule

// File: rtl/dz_matrix_scan.sv
// Bicolor dot-matrix scanner: walks the rows of the front frame, applies
// ghost blanking and blink, and swaps frames only at a frame boundary.
module dz_matrix_scan
  import dz_pkg::*;
#(
  parameter  int ROWS         = 8,
  parameter  int COLS         = 8,
  parameter  int SCAN_DIV     = 1,
  parameter  int BLINK_FRAMES = 64,
  localparam int RW           = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 blink_en,
  dz_matrix_scan_if.slave      wr,
  output logic                 frame_start,
  output logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      colr,
  output logic [COLS-1:0]      colg,
  output scan_state_e          dbg_state
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);
  localparam logic [COLS-1:0] COL_BLANK = {COLS{COL_OFF}};

  scan_state_e     state_q, state_d;
  logic [DW-1:0]   div_q;
  logic [RW-1:0]   row_idx_q;
  logic [FW-1:0]   frame_q;
  logic            blink_phase_q;
  logic            commit_done_q;
  logic [COLS-1:0] rd_r, rd_g;

  logic running, div_wrap, row_last, frame_last, end_of_frame;
  logic swap, ghost, dark, wr_ready_c;

  assign running      = (state_q != ST_OFF) && en;
  assign div_wrap     = (div_q == DW'(SCAN_DIV - 1));
  assign row_last     = (row_idx_q == RW'(ROWS - 1));
  assign frame_last   = (frame_q == FW'(BLINK_FRAMES - 1));
  assign end_of_frame = div_wrap && row_last;
  // A pending frame goes live at the frame boundary, or at once if scanning stops.
  assign swap         = (state_q == ST_PEND) && (!en || end_of_frame);
  assign ghost        = (SCAN_DIV > 1) && (div_q == '0);
  assign dark         = blink_en && blink_phase_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_OFF;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (en) state_d = ST_SCAN;
      ST_SCAN: begin
        if (!en)            state_d = ST_OFF;
        else if (wr.commit) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (!en)               state_d = ST_OFF;
        else if (end_of_frame) state_d = ST_SCAN;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // FSM outputs: writes are held off while a frame waits to be shown.
  always_comb begin
    wr_ready_c = (state_q != ST_PEND);
    dbg_state  = state_q;
  end

  assign wr.wr_ready    = wr_ready_c;
  assign wr.commit_done = commit_done_q;

  // Row dwell divider, row index and frame counter; all idle at 0 when stopped.
  always_ff @(posedge clk) begin
    if (rst || !running) begin
      div_q     <= '0;
      row_idx_q <= '0;
      frame_q   <= '0;
    end else if (div_wrap) begin
      div_q <= '0;
      if (row_last) begin
        row_idx_q <= '0;
        frame_q   <= frame_last ? '0 : frame_q + 1'b1;
      end else begin
        row_idx_q <= row_idx_q + 1'b1;
      end
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Blink phase flips every BLINK_FRAMES frames, only while blink is enabled.
  always_ff @(posedge clk) begin
    if (rst || !running || !blink_en)   blink_phase_q <= 1'b0;
    else if (end_of_frame && frame_last) blink_phase_q <= ~blink_phase_q;
  end

  // Swap acknowledge, one cycle after the front pointer moves.
  always_ff @(posedge clk) begin
    if (rst) commit_done_q <= 1'b0;
    else     commit_done_q <= swap;
  end

  // Registered display outputs; row and column bits come from the same row_idx.
  always_ff @(posedge clk) begin
    if (rst || !running) begin
      row         <= '1;
      colr        <= COL_BLANK;
      colg        <= COL_BLANK;
      frame_start <= 1'b0;
    end else begin
      row         <= ~(ROW_ONE << row_idx_q);
      colr        <= (ghost || dark) ? COL_BLANK : rd_r;
      colg        <= (ghost || dark) ? COL_BLANK : rd_g;
      frame_start <= (row_idx_q == '0) && (div_q == '0);
    end
  end

  dz_frame_buf #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_frame_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr.wr_valid && wr_ready_c),
    .wr_row (wr.wr_row),
    .wr_r   (wr.wr_r),
    .wr_g   (wr.wr_g),
    .swap   (swap),
    .rd_row (row_idx_q),
    .rd_r   (rd_r),
    .rd_g   (rd_g)
  );

endmodule
